// File: rtl/qspi_master_tx_if.sv
// Bus bundle between a QSPI write-frame source and its requester/observer.
// The master modport is the transmitter side; slave is the requester/bench side.
interface qspi_master_tx_if #(
  parameter int unsigned BYTES = 16
);
  logic               ld;
  logic [7:0]         base_addr;
  logic [8*BYTES-1:0] text_in;
  logic               busy;
  logic               done;
  logic               qspi_cs;
  logic               qspi_clk;
  logic [3:0]         qspi_io_o;
  logic               qspi_oe;

  modport master (
    input  ld, base_addr, text_in,
    output busy, done, qspi_cs, qspi_clk, qspi_io_o, qspi_oe
  );

  modport slave (
    output ld, base_addr, text_in,
    input  busy, done, qspi_cs, qspi_clk, qspi_io_o, qspi_oe
  );
endinterface

// File: rtl/qspi_master_tx.sv
// Quad-SPI write-frame transmitter: one address byte followed by BYTES data bytes,
// high nibble first, mode 0 clocking. All pins are registered one cycle behind the FSM.
module qspi_master_tx #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned BYTES    = 16
) (
  input  logic              sclk,
  input  logic              rst_n,
  qspi_master_tx_if.master  bus
);

  localparam int unsigned NIB  = 2 * (BYTES + 1);
  localparam int unsigned SW   = 8 * (BYTES + 1);
  localparam int unsigned PMAX = (CLK_DIV > CS_SETUP) ?
                                 ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                                 ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int unsigned PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StFin} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            hi_q, hi_d;        // second (qspi_clk high) half of the current nibble
  logic [5:0]      nib_q, nib_d;
  logic [SW-1:0]   sreg_q, sreg_d;

  logic            cs_q, cs_d;
  logic            clk_q, clk_d;
  logic [3:0]      io_q, io_d;
  logic            oe_q, oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // State, counters, shift register and registered pin outputs.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      phase_q <= '0;
      hi_q    <= 1'b0;
      nib_q   <= '0;
      sreg_q  <= '0;
      cs_q    <= 1'b1;
      clk_q   <= 1'b0;
      io_q    <= 4'h0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      nib_q   <= nib_d;
      sreg_q  <= sreg_d;
      cs_q    <= cs_d;
      clk_q   <= clk_d;
      io_q    <= io_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counter and shift-register update.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    nib_d   = nib_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      StIdle: begin
        phase_d = '0;
        hi_d    = 1'b0;
        nib_d   = '0;
        // done_q still high means the previous frame's done cycle: ld is ignored there.
        if (bus.ld && !done_q) begin
          sreg_d  = {bus.base_addr, bus.text_in};
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (phase_q == PW'(CS_SETUP - 1)) begin
          phase_d = '0;
          state_d = StShift;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      StShift: begin
        if (phase_q == PW'(CLK_DIV - 1)) begin
          phase_d = '0;
          hi_d    = ~hi_q;
          if (hi_q) begin
            // End of the high half: next nibble appears with the qspi_clk fall.
            sreg_d = {sreg_q[SW-5:0], 4'h0};
            if (nib_q == 6'(NIB - 1)) begin
              nib_d   = '0;
              state_d = StHold;
            end else begin
              nib_d = nib_q + 6'd1;
            end
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      StHold: begin
        if (phase_q == PW'(CS_HOLD - 1)) begin
          phase_d = '0;
          state_d = StFin;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Pin values decoded from the current state; registered above.
  always_comb begin
    cs_d   = 1'b1;
    clk_d  = 1'b0;
    io_d   = 4'h0;
    oe_d   = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      StSetup, StHold: begin
        cs_d   = 1'b0;
        oe_d   = 1'b1;
        busy_d = 1'b1;
        io_d   = sreg_q[SW-1 -: 4];
      end
      StShift: begin
        cs_d   = 1'b0;
        oe_d   = 1'b1;
        busy_d = 1'b1;
        clk_d  = hi_q;
        io_d   = sreg_q[SW-1 -: 4];
      end
      StFin: begin
        done_d = 1'b1;
      end
      default: begin
        cs_d = 1'b1;
      end
    endcase
  end

  assign bus.qspi_cs   = cs_q;
  assign bus.qspi_clk  = clk_q;
  assign bus.qspi_io_o = io_q;
  assign bus.qspi_oe   = oe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
